// File: rtl/if_stage_ctrl_pkg.sv
// Shared fetch-stage constants and types for the IF stage and the hazard unit.
package if_stage_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

  // One action per cycle, listed from highest to lowest priority.
  typedef enum logic [1:0] {
    ACT_FLUSH,
    ACT_STALL,
    ACT_WAIT,
    ACT_FETCH
  } fetch_act_e;

  // Instruction addresses are word aligned; clear the byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_stage_ctrl_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // Count qualifying events; reset wins over an increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch stage control: PC register, IF/ID register, imem handshake and
// saturating stall / flush / imem-wait counters.
module if_stage_ctrl
  import if_stage_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             IF_ID_write,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      IF_ID_pc_plus4,
  output logic [31:0]      IF_ID_instr,
  output logic             IF_ID_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] imem_wait_count
);

  logic        stall;
  fetch_act_e  act;
  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;

  // Priority decode: flush beats stall beats imem wait beats a normal fetch.
  always_comb begin
    stall = ~(pc_write & IF_ID_write);
    act   = ACT_FETCH;
    if (branch_taken) begin
      act = ACT_FLUSH;
    end else if (stall) begin
      act = ACT_STALL;
    end else if (!imem_ready) begin
      act = ACT_WAIT;
    end
  end

  assign pc_plus4_p0 = pc_p0 + PC_INC;
  assign imem_addr   = pc_p0;
  assign imem_req    = ~rst;

  // ---- stage p0 -> p1: PC register (holds on stall and imem wait)
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0 <= align_word(RESET_PC);
    end else begin
      unique case (act)
        ACT_FLUSH: pc_p0 <= align_word(branch_target);
        ACT_FETCH: pc_p0 <= pc_plus4_p0;
        default:   pc_p0 <= pc_p0;
      endcase
    end
  end

  // ---- stage p1: IF/ID register (bubble on flush or wait, hold on stall)
  always_ff @(posedge clk) begin
    if (rst) begin
      IF_ID_instr    <= NOP_INSTR;
      IF_ID_pc_plus4 <= '0;
      IF_ID_valid    <= 1'b0;
    end else begin
      unique case (act)
        ACT_FLUSH, ACT_WAIT: begin
          IF_ID_instr <= NOP_INSTR;
          IF_ID_valid <= 1'b0;
        end
        ACT_FETCH: begin
          IF_ID_instr    <= imem_rdata;
          IF_ID_pc_plus4 <= pc_plus4_p0;
          IF_ID_valid    <= 1'b1;
        end
        default: begin
          IF_ID_instr    <= IF_ID_instr;
          IF_ID_pc_plus4 <= IF_ID_pc_plus4;
          IF_ID_valid    <= IF_ID_valid;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act == ACT_STALL),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act == ACT_FLUSH),
    .count (flush_count)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act == ACT_WAIT),
    .count (imem_wait_count)
  );

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Scoreboard bench for if_stage_ctrl: the driver predicts the post-edge state
// with a behavioural model and queues it; the monitor compares after each edge.
module tb_if_stage_ctrl;

  localparam int          CNT_W    = 16;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             pc_write;
  logic             IF_ID_write;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             imem_ready;
  logic [31:0]      IF_ID_pc_plus4;
  logic [31:0]      IF_ID_instr;
  logic             IF_ID_valid;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] imem_wait_count;

  if_stage_ctrl #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_write        (pc_write),
    .IF_ID_write     (IF_ID_write),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .IF_ID_pc_plus4  (IF_ID_pc_plus4),
    .IF_ID_instr     (IF_ID_instr),
    .IF_ID_valid     (IF_ID_valid),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .imem_wait_count (imem_wait_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        req;
    int          sc;
    int          fc;
    int          wc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state (architectural view, plain integers for counters)
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc4   = 32'h0;
  logic        m_valid = 1'b0;
  int          m_sc = 0, m_fc = 0, m_wc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model applies the fetch rules and queues the result.
  task automatic cyc(input bit r, input bit pw, input bit iw, input bit bt,
                     input logic [31:0] tgt, input logic [31:0] rd, input bit rdy);
    exp_t e;
    @(negedge clk);
    rst = r; pc_write = pw; IF_ID_write = iw; branch_taken = bt;
    branch_target = tgt; imem_rdata = rd; imem_ready = rdy;
    if (r) begin
      m_pc = RESET_PC; m_instr = NOP; m_pc4 = 0; m_valid = 0;
      m_sc = 0; m_fc = 0; m_wc = 0;
    end else if (bt) begin
      m_pc = {tgt[31:2], 2'b00}; m_instr = NOP; m_valid = 0;
      if (m_fc < CNT_MAX) m_fc++;
    end else if (!(pw && iw)) begin
      if (m_sc < CNT_MAX) m_sc++;
    end else if (!rdy) begin
      m_instr = NOP; m_valid = 0;
      if (m_wc < CNT_MAX) m_wc++;
    end else begin
      m_instr = rd; m_pc4 = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.req = !r; e.sc = m_sc; e.fc = m_fc; e.wc = m_wc;
    sb.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] rd);
    cyc(0, 1, 1, 0, 32'h0, rd, 1);
  endtask

  // Monitor: compare DUT state just after every active edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("imem_addr",       imem_addr,              e.pc);
      chk("imem_req",        {31'h0, imem_req},      {31'h0, e.req});
      chk("IF_ID_instr",     IF_ID_instr,            e.instr);
      chk("IF_ID_pc_plus4",  IF_ID_pc_plus4,         e.pc4);
      chk("IF_ID_valid",     {31'h0, IF_ID_valid},   {31'h0, e.valid});
      chk("stall_count",     {16'h0, stall_count},   e.sc);
      chk("flush_count",     {16'h0, flush_count},   e.fc);
      chk("imem_wait_count", {16'h0, imem_wait_count}, e.wc);
    end
  end

  initial begin
    rst = 1'b1; pc_write = 1'b0; IF_ID_write = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_rdata = 32'h0; imem_ready = 1'b0;

    // T1: reset, then three back-to-back fetches
    cyc(1, 1, 1, 0, 32'h0, 32'h0, 1);
    fetch(32'hAAAA_0001);
    fetch(32'hBBBB_0002);
    fetch(32'hCCCC_0003);

    // T2: redirect to 8, fetch once, hold two cycles (either write enable low), resume
    cyc(0, 1, 1, 1, 32'h8, 32'hDEAD_BEEF, 1);
    fetch(32'h1111_0008);
    cyc(0, 0, 0, 0, 32'h0, 32'h2222_2222, 1);
    cyc(0, 1, 0, 0, 32'h0, 32'h3333_3333, 1);
    fetch(32'h4444_000C);

    // T3: branch overrides a coincident stall; target low bits dropped
    cyc(0, 0, 1, 1, 32'h43, 32'h5555_5555, 1);
    fetch(32'h6666_0040);

    // T4: three imem wait cycles then a successful fetch
    cyc(0, 1, 1, 0, 32'h0, 32'h7777_7777, 0);
    cyc(0, 1, 1, 0, 32'h0, 32'h7777_7777, 0);
    cyc(0, 1, 1, 0, 32'h0, 32'h7777_7777, 0);
    fetch(32'h8888_0044);

    // T5: PC wraps from FFFF_FFFC; stall counter saturates
    cyc(0, 1, 1, 1, 32'hFFFF_FFFF, 32'h0, 0);
    fetch(32'h9999_FFFC);
    for (int i = 0; i < CNT_MAX + 6; i++) cyc(0, 0, 1, 0, 32'h0, 32'h0, 1);
    fetch(32'hAAAA_0000);

    // T6: reset during a stall, and during an imem wait
    cyc(0, 1, 0, 0, 32'h0, 32'h0, 1);
    cyc(0, 1, 0, 0, 32'h0, 32'h0, 1);
    cyc(1, 1, 0, 0, 32'h0, 32'h0, 1);
    fetch(32'hBBBB_0000);
    cyc(0, 1, 1, 1, 32'h100, 32'h0, 1);
    cyc(0, 1, 1, 0, 32'h0, 32'h0, 0);
    cyc(1, 1, 1, 0, 32'h0, 32'h0, 0);
    fetch(32'hCCCC_0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0),
          ($urandom_range(99) < 88),
          ($urandom_range(99) < 88),
          ($urandom_range(99) < 10),
          $urandom(), $urandom(),
          ($urandom_range(99) < 75));
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
